// File: rtl/jstk_spi_responder.sv
// -----------------------------------------------------------------------------
// jstk_spi_responder
//
// SPI mode-0 slave (MSB first) that exchanges one fixed-length frame of
// FRAME_BYTES bytes per slave-select low period. All SPI pins are
// oversampled in the clk_i domain, so clk_i must run at least 8x sclk_i.
//
// Ports
//   clk_i           : system clock, rising edge
//   reset_n_i       : asynchronous active-low reset
//   ss_i            : SPI slave select, active low (asynchronous)
//   sclk_i          : SPI clock, idle low (asynchronous)
//   mosi_i          : master-out data (asynchronous)
//   miso_o          : slave-out data, 0 outside a frame
//   tx_data_i       : response frame, MSB byte sent first, sampled at frame start
//   rx_data_o       : last complete received frame, first byte in the MSBs
//   rx_valid_o      : one-cycle pulse when rx_data_o is updated
//   rx_byte_o       : most recent completed byte
//   rx_byte_valid_o : one-cycle pulse per completed byte
//   abort_o         : one-cycle pulse when slave select rises before a full frame
//   busy_o          : high while a frame is being shifted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module jstk_spi_responder #(
    parameter int FRAME_BYTES = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     ss_i,
    input  logic                     sclk_i,
    input  logic                     mosi_i,
    output logic                     miso_o,
    input  logic [8*FRAME_BYTES-1:0] tx_data_i,
    output logic [8*FRAME_BYTES-1:0] rx_data_o,
    output logic                     rx_valid_o,
    output logic [7:0]               rx_byte_o,
    output logic                     rx_byte_valid_o,
    output logic                     abort_o,
    output logic                     busy_o
);

    localparam int FRAME_BITS = 8 * FRAME_BYTES;
    // The counter is only 6 bits wide, so a 64-bit frame completes when the
    // counter wraps back to zero; the low six bits of the length cover both.
    localparam logic [6:0] FRAME_BITS_W = 7'(FRAME_BITS);
    localparam logic [5:0] FRAME_CNT    = FRAME_BITS_W[5:0];

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic r_ssMeta,   r_ssSync,   r_ssHist;
    logic r_sclkMeta, r_sclkSync, r_sclkHist;
    logic r_mosiMeta, r_mosiSync, r_mosiHist;

    logic [FRAME_BITS-1:0] r_txShift;
    logic [FRAME_BITS-1:0] r_rxShift;
    logic [5:0]            r_bitCnt;
    logic                  r_riseDone;

    logic [FRAME_BITS-1:0] r_rxData;
    logic                  r_rxValid;
    logic [7:0]            r_rxByte;
    logic                  r_rxByteValid;
    logic                  r_abort;

    logic w_ssRise, w_ssFall, w_sclkRise, w_sclkFall;
    logic w_byteDone, w_frameDone;

    // Two-flop synchronizers plus a history flop per pin. Everything resets
    // low; in particular ss reads as "selected" after reset, so a frame that
    // was already running is ignored until the master raises ss.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ssMeta   <= 1'b0;
            r_ssSync   <= 1'b0;
            r_ssHist   <= 1'b0;
            r_sclkMeta <= 1'b0;
            r_sclkSync <= 1'b0;
            r_sclkHist <= 1'b0;
            r_mosiMeta <= 1'b0;
            r_mosiSync <= 1'b0;
            r_mosiHist <= 1'b0;
        end else begin
            r_ssMeta   <= ss_i;
            r_ssSync   <= r_ssMeta;
            r_ssHist   <= r_ssSync;
            r_sclkMeta <= sclk_i;
            r_sclkSync <= r_sclkMeta;
            r_sclkHist <= r_sclkSync;
            r_mosiMeta <= mosi_i;
            r_mosiSync <= r_mosiMeta;
            r_mosiHist <= r_mosiSync;
        end
    end

    assign w_ssRise   =  r_ssSync   & ~r_ssHist;
    assign w_ssFall   = ~r_ssSync   &  r_ssHist;
    assign w_sclkRise =  r_sclkSync & ~r_sclkHist;
    assign w_sclkFall = ~r_sclkSync &  r_sclkHist;

    // Byte and frame completion are judged the cycle after the sclk rise that
    // advanced the counter, which is what makes the result pulses land one
    // cycle after the final bit is captured.
    assign w_byteDone  = r_riseDone && (r_bitCnt[2:0] == 3'd0);
    assign w_frameDone = r_riseDone && (r_bitCnt == FRAME_CNT);

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A completed frame wins over a simultaneous ss rise,
    // since the frame is no longer short at that point.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HOLD: begin
                if (r_ssSync) begin
                    w_nextState = IDLE;
                end
            end
            IDLE: begin
                if (w_ssFall) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (w_frameDone) begin
                    w_nextState = HOLD;
                end else if (w_ssRise) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = HOLD;
            end
        endcase
    end

    // Shift registers, bit counter and result pulses. An ss rise masks any
    // sclk edge detected in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_txShift     <= '0;
            r_rxShift     <= '0;
            r_bitCnt      <= 6'd0;
            r_riseDone    <= 1'b0;
            r_rxData      <= '0;
            r_rxValid     <= 1'b0;
            r_rxByte      <= 8'd0;
            r_rxByteValid <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_riseDone    <= 1'b0;
            r_rxValid     <= 1'b0;
            r_rxByteValid <= 1'b0;
            r_abort       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ssFall) begin
                        r_txShift <= tx_data_i;
                        r_rxShift <= '0;
                        r_bitCnt  <= 6'd0;
                    end
                end
                SHIFT: begin
                    if (w_byteDone) begin
                        r_rxByte      <= r_rxShift[7:0];
                        r_rxByteValid <= 1'b1;
                    end
                    if (w_frameDone) begin
                        r_rxData  <= r_rxShift;
                        r_rxValid <= 1'b1;
                    end else if (w_ssRise) begin
                        r_abort <= 1'b1;
                    end else if (w_sclkRise) begin
                        r_rxShift  <= {r_rxShift[FRAME_BITS-2:0], r_mosiHist};
                        r_bitCnt   <= r_bitCnt + 6'd1;
                        r_riseDone <= 1'b1;
                    end else if (w_sclkFall) begin
                        r_txShift <= {r_txShift[FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign miso_o          = (r_state == SHIFT) & r_txShift[FRAME_BITS-1];
    assign busy_o          = (r_state == SHIFT);
    assign rx_data_o       = r_rxData;
    assign rx_valid_o      = r_rxValid;
    assign rx_byte_o       = r_rxByte;
    assign rx_byte_valid_o = r_rxByteValid;
    assign abort_o         = r_abort;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_jstk_spi_responder
//
// Directed bench for jstk_spi_responder with FRAME_BYTES = 5. A bit-banged
// SPI master drives frames at sclk = clk/16; expected bytes, frames, aborts
// and miso words go into queues, and a monitor compares them whenever the
// responder raises one of its result pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jstk_spi_responder;

    logic        clk;
    logic        reset_n;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic        miso_o;
    logic [39:0] tx_data;
    logic [39:0] rx_data_o;
    logic        rx_valid_o;
    logic [7:0]  rx_byte_o;
    logic        rx_byte_valid_o;
    logic        abort_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  expBytes[$];
    logic [39:0] expFrames[$];
    logic        expAborts[$];
    logic [39:0] expMiso[$];

    logic [39:0] misoWord;
    logic        extraMiso;

    jstk_spi_responder #(.FRAME_BYTES(5)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ss_i            (ss),
        .sclk_i          (sclk),
        .mosi_i          (mosi),
        .miso_o          (miso_o),
        .tx_data_i       (tx_data),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_byte_o       (rx_byte_o),
        .rx_byte_valid_o (rx_byte_valid_o),
        .abort_o         (abort_o),
        .busy_o          (busy_o)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: every check and every error passes through here.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue the five byte pulses and the frame pulse a complete frame produces.
    task automatic expectFrame(input logic [39:0] word);
        for (int b = 0; b < 5; b++) begin
            expBytes.push_back(word[39-8*b -: 8]);
        end
        expFrames.push_back(word);
    endtask

    // Queue only the leading complete bytes of a frame that will not finish.
    task automatic expectBytes(input logic [39:0] word, input int n);
        for (int b = 0; b < n; b++) begin
            expBytes.push_back(word[39-8*b -: 8]);
        end
    endtask

    // Bit-banged mode-0 master: mosi set half a period before each rise, miso
    // captured at each rise. eventKind 1 pulses reset and eventKind 2 swaps
    // tx_data at the start of bit eventBit. Bits past 40 send ones.
    task automatic applyStimulus(input logic [39:0] mosiWord, input int nBits, input int gapCycles,
                                 input int eventBit, input int eventKind, input logic [39:0] eventTx,
                                 output logic [39:0] misoOut, output logic extraOut);
        misoOut  = '0;
        extraOut = 1'b0;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("busy_in_frame", {63'd0, busy_o}, 64'd1);
        for (int i = 0; i < nBits; i++) begin
            if (i == eventBit && eventKind == 1) begin
                reset_n = 1'b0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                repeat (2) @(negedge clk);
                checkOutput("rx_data_after_reset", {24'd0, rx_data_o}, 64'd0);
                checkOutput("busy_after_reset", {63'd0, busy_o}, 64'd0);
            end
            if (i == eventBit && eventKind == 2) begin
                tx_data = eventTx;
            end
            mosi = (i < 40) ? mosiWord[39-i] : 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            if (i < 40) begin
                misoOut[39-i] = miso_o;
            end else begin
                extraOut = extraOut | miso_o;
            end
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (gapCycles) @(negedge clk);
    endtask

    // Monitor: every result pulse pops its queue; a pulse with nothing queued
    // is itself an error.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_byte_valid_o) begin
                if (expBytes.size() == 0) begin
                    checkOutput("unexpected_rx_byte_valid", 64'd1, 64'd0);
                end else begin
                    checkOutput("rx_byte", {56'd0, rx_byte_o}, {56'd0, expBytes.pop_front()});
                end
            end
            if (rx_valid_o) begin
                if (expFrames.size() == 0) begin
                    checkOutput("unexpected_rx_valid", 64'd1, 64'd0);
                end else begin
                    checkOutput("rx_data", {24'd0, rx_data_o}, {24'd0, expFrames.pop_front()});
                end
            end
            if (abort_o) begin
                if (expAborts.size() == 0) begin
                    checkOutput("unexpected_abort", 64'd1, 64'd0);
                end else begin
                    checkOutput("abort", {63'd0, abort_o}, {63'd0, expAborts.pop_front()});
                end
            end
        end
    end

    // Watchdog so the run always ends even if the flow stalls.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        reset_n = 1'b0;
        ss      = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        tx_data = '0;
        repeat (5) @(negedge clk);
        checkOutput("reset_rx_data", {24'd0, rx_data_o}, 64'd0);
        checkOutput("reset_rx_valid", {63'd0, rx_valid_o}, 64'd0);
        checkOutput("reset_rx_byte", {56'd0, rx_byte_o}, 64'd0);
        checkOutput("reset_rx_byte_valid", {63'd0, rx_byte_valid_o}, 64'd0);
        checkOutput("reset_abort", {63'd0, abort_o}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("reset_miso", {63'd0, miso_o}, 64'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle_busy", {63'd0, busy_o}, 64'd0);

        // Full frame.
        tx_data = 40'h123456789A;
        expectFrame(40'h8300000000);
        expMiso.push_back(40'h123456789A);
        applyStimulus(40'h8300000000, 40, 10, -1, 0, '0, misoWord, extraMiso);
        checkOutput("miso_full", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});

        // Short frame of 20 bits, then a normal frame.
        tx_data = 40'h0F1E2D3C4B;
        expectBytes(40'hC3A55A0000, 2);
        expAborts.push_back(1'b1);
        applyStimulus(40'hC3A55A0000, 20, 10, -1, 0, '0, misoWord, extraMiso);
        checkOutput("rx_data_kept", {24'd0, rx_data_o}, 64'h8300000000);
        expectFrame(40'h0123456789);
        expMiso.push_back(40'h0F1E2D3C4B);
        applyStimulus(40'h0123456789, 40, 10, -1, 0, '0, misoWord, extraMiso);
        checkOutput("miso_after_abort", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});

        // Reset at bit 12 with ss held low, then a normal frame.
        tx_data = 40'h13579BDF02;
        expectBytes(40'hDEADBEEF00, 1);
        applyStimulus(40'hDEADBEEF00, 40, 10, 12, 1, '0, misoWord, extraMiso);
        expectFrame(40'hCAFEF00D42);
        expMiso.push_back(40'h13579BDF02);
        applyStimulus(40'hCAFEF00D42, 40, 10, -1, 0, '0, misoWord, extraMiso);
        checkOutput("miso_after_reset", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});

        // 48 sclk pulses in one frame.
        tx_data = 40'h2468ACE013;
        expectFrame(40'h1122334455);
        expMiso.push_back(40'h2468ACE013);
        applyStimulus(40'h1122334455, 48, 10, -1, 0, '0, misoWord, extraMiso);
        checkOutput("miso_extra_frame", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});
        checkOutput("miso_extra_bits", {63'd0, extraMiso}, 64'd0);

        // tx_data changed mid-frame.
        tx_data = 40'hAAAAAAAAAA;
        expectFrame(40'h0F0F0F0F0F);
        expMiso.push_back(40'hAAAAAAAAAA);
        applyStimulus(40'h0F0F0F0F0F, 40, 10, 10, 2, 40'h5555555555, misoWord, extraMiso);
        checkOutput("miso_tx_stable", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});

        // Back-to-back frames with ss high for 4 clk cycles.
        tx_data = 40'h0102030405;
        expectFrame(40'hA1B2C3D4E5);
        expMiso.push_back(40'h0102030405);
        applyStimulus(40'hA1B2C3D4E5, 40, 4, -1, 0, '0, misoWord, extraMiso);
        checkOutput("miso_b2b_first", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});
        expectFrame(40'h5A6B7C8D9E);
        expMiso.push_back(40'h0102030405);
        applyStimulus(40'h5A6B7C8D9E, 40, 10, -1, 0, '0, misoWord, extraMiso);
        checkOutput("miso_b2b_second", {24'd0, misoWord}, {24'd0, expMiso.pop_front()});

        // Anything still queued was expected but never seen.
        repeat (20) @(negedge clk);
        checkOutput("pending_bytes", 64'(expBytes.size()), 64'd0);
        checkOutput("pending_frames", 64'(expFrames.size()), 64'd0);
        checkOutput("pending_aborts", 64'(expAborts.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
